waveform_player_mc: RTL and testbench
=====================================

Name: waveform_player_mc

Overview:
- Multi-channel, single-clock waveform store-and-playback engine for pipe-loaded stimulus waveforms, such as spindle or afferent drive.
- The host loads or reads back each channel's sample memory 16 bits at a time over a pipe.
- A playback FSM steps a shared sample index on each pop_en strobe, in loop or one-shot mode, with a programmable length.
- Each channel output can be overridden by a trigger-supplied value.

Parameters:
- NUM_CH, 4: number of independent waveform channels (1..16).
- DEPTH, 2048: samples per channel (power of two).
- DATA_W, 32: sample width; must be a multiple of 16. Derived: HW = DATA_W/16, AW = clog2(DEPTH), CW = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  single clock for pipe and playback.
- reset  in  1  asynchronous, active-high.
- pipe_in_write  in  1  write pipe_in_data at the pipe pointer, then advance the pointer.
- pipe_in_data  in  16  host halfword.
- pipe_out_read  in  1  advance the pipe pointer (readback).
- pipe_out_data  out  16  halfword at the pipe pointer (registered).
- pipe_ch_sel  in  CW  channel targeted by pipe accesses.
- pipe_rewind  in  1  set the pipe pointer to 0.
- wave_len  in  AW+1  playback length in samples; 0 or values > DEPTH mean DEPTH.
- one_shot  in  1  1 = stop at the end, 0 = loop.
- start  in  1  pulse; begin playback at sample 0.
- stop  in  1  pulse; return to IDLE.
- pop_en  in  1  sample-advance strobe (one clk wide, already in the clk domain).
- is_from_trigger  in  NUM_CH  per-channel bypass select.
- data_from_trig  in  NUM_CH*DATA_W  per-channel bypass data; channel c is at [c*DATA_W +: DATA_W].
- wave  out  NUM_CH*DATA_W  per-channel output, same packing.
- sample_idx  out  AW  current play address.
- busy  out  1  state is RUN.
- done  out  1  one-shot completed (state HOLD).

Behaviour:
- Reset: all pointers 0, state IDLE, RAM output registers 0, pipe_out_data 0, busy 0, done 0. wave = bypass value or 0 per channel. RAM contents are not cleared.
- Pipe pointer pp: AW + clog2(HW) bits. Word = pp / HW; halfword = pp % HW, with halfword 0 = bits [15:0] (low half first).
- Pipe pointer advances by 1 on pipe_in_write or pipe_out_read, once per cycle even if both are asserted.
- The pipe pointer wraps from DEPTH*HW-1 to 0.
- pipe_rewind has priority over pipe_in_write and pipe_out_read: a write in the same cycle is dropped and the pointer becomes 0.
- Writes modify only the selected halfword of the selected channel.
- pipe_out_data is registered from a synchronous read of the selected channel at the current pointer, so it is valid one clk after the pointer or pipe_ch_sel changes.
- FSM states:
  - IDLE: idx = 0.
  - RUN.
  - HOLD: idx frozen at len-1.
- FSM transitions:
  - start in any state → RUN, idx = 0, len latched from wave_len.
  - stop (when start is not asserted) → IDLE.
  - start has priority over stop and pop_en.
  - In RUN, on pop_en: if idx == len-1, go to HOLD when one_shot = 1, else set idx = 0; otherwise idx + 1.
  - pop_en is ignored in IDLE and HOLD.
  - one_shot is sampled at each wrap decision.
- Output latency: the per-channel RAM port B read is synchronous, so wave shows RAM[idx] one clk after idx updates.
- wave channel c = is_from_trigger[c] ? data_from_trig slice : RAM output register. This mux is combinational, and bypass takes effect the same cycle.
- RAM is read-first: a pipe write to the address being played is visible from the following read.
- Reset asserted mid-playback forces IDLE immediately (asynchronous).

Decomposition:
- Shared package waveform_pkg:
  - PIPE_W = 16.
  - FSM state typedef {IDLE, RUN, HOLD}.
  - clog2 helper function.
- Sub-module waveform_ram_ch: simple dual-port RAM, DEPTH x DATA_W.
  - Port A: HW-bit halfword write enable plus synchronous read.
  - Port B: synchronous read only.
  - Instantiated NUM_CH times via generate.
- Top level: pipe pointer, channel decode, FSM, output mux.

Test Plan:
- Load and readback, defaults: rewind, ch 2, write 0x0001, 0x0002, 0x0003, 0x0004 → rewind, 4 reads give 0x0001..0x0004. RAM ch 2 word 0 = 0x00020001, word 1 = 0x00040003. Other channels unchanged.
- Loop playback: ch 0 words 0..3 = 10, 20, 30, 40; wave_len = 4, one_shot = 0; start, then 6 pop_en pulses → ch 0 wave sequence 10, 20, 30, 40, 10, 20, 30. Each value appears 1 clk after its idx update. busy stays 1.
- One-shot: same load; one_shot = 1, wave_len = 3, start, 5 pops → wave 10, 20, 30, then held at 30. done = 1, busy = 0, sample_idx = 2. A new start gives done = 0 and wave 10.
- Bypass: is_from_trigger = 4'b0010, data_from_trig ch 1 = 0xDEADBEEF → ch 1 wave = 0xDEADBEEF the same cycle. Other channels still play. Deasserting restores the RAM value.
- Boundaries:
  - wave_len = 0 plays 2048 samples before wrap.
  - 4096 pipe writes wrap the pointer to 0.
  - start and stop in the same cycle → RUN at idx 0.
  - rewind during write drops the write.
- Asynchronous reset mid-RUN (idx = 5): wave, sample_idx, busy and pipe_out_data go to 0 without a clock edge. RAM data is retained, confirmed by readback.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared definitions for the multi-channel waveform player.
// Contents: pipe halfword width, playback FSM state type, and a constant-safe
// ceil(log2) helper used to size address and pointer fields.
package waveform_pkg;

  localparam int unsigned PIPE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/waveform_ram_ch.sv
// One channel of sample storage: simple dual-port DEPTH x DATA_W RAM.
// Ports:
//   clk, reset          clock; async active-high reset clears the read registers only
//   a_we [HW]           per-halfword write enable (halfword 0 = bits [15:0])
//   a_addr, a_wdata     port A word address and halfword write data
//   a_rdata             port A registered read data (read-first)
//   b_addr, b_rdata     port B playback address and registered read data (read-first)
module waveform_ram_ch
  import waveform_pkg::*;
#(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned HW    = DATA_W / PIPE_W,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HW-1:0]     a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [PIPE_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [AW-1:0]     b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_d, a_rdata_q;
  logic [DATA_W-1:0] b_rdata_d, b_rdata_q;

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    for (int h = 0; h < HW; h++) begin
      if (a_we[h]) mem_q[a_addr][h*PIPE_W +: PIPE_W] <= a_wdata;
    end
  end

  always_comb begin
    a_rdata_d = mem_q[a_addr];
    b_rdata_d = mem_q[b_addr];
  end

  // Non-blocking update of mem_q makes both ports read-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/waveform_player_mc.sv
// Multi-channel waveform store-and-playback engine.
// Ports:
//   clk, reset                 single clock, async active-high reset
//   pipe_in_write/pipe_in_data host halfword write at the pipe pointer, then advance
//   pipe_out_read/pipe_out_data readback advance / registered halfword at the pointer
//   pipe_ch_sel, pipe_rewind   pipe channel select, pointer clear (wins over write/read)
//   wave_len, one_shot         playback length (0 or >DEPTH = DEPTH), stop-at-end select
//   start, stop, pop_en        FSM control pulses and sample-advance strobe
//   is_from_trigger, data_from_trig  per-channel combinational bypass
//   wave, sample_idx, busy, done     per-channel outputs and playback status
module waveform_player_mc
  import waveform_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned HW    = DATA_W / PIPE_W,
  localparam int unsigned AW    = clog2(DEPTH),
  localparam int unsigned CW    = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_in_write,
  input  logic [PIPE_W-1:0]        pipe_in_data,
  input  logic                     pipe_out_read,
  output logic [PIPE_W-1:0]        pipe_out_data,
  input  logic [CW-1:0]            pipe_ch_sel,
  input  logic                     pipe_rewind,
  input  logic [AW:0]              wave_len,
  input  logic                     one_shot,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pop_en,
  input  logic [NUM_CH-1:0]        is_from_trigger,
  input  logic [NUM_CH*DATA_W-1:0] data_from_trig,
  output logic [NUM_CH*DATA_W-1:0] wave,
  output logic [AW-1:0]            sample_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned HWB = clog2(HW);
  localparam int unsigned PW  = AW + HWB;
  localparam int unsigned HSW = (HWB > 0) ? HWB : 1;
  // Explicit wrap keeps the pointer correct when HW is not a power of two.
  localparam logic [PW-1:0] PP_LAST = PW'(DEPTH * HW - 1);
  localparam logic [AW:0]   LEN_MAX = (AW + 1)'(DEPTH);

  // ---------------- Pipe pointer and channel decode ----------------
  logic [PW-1:0]  pp_d, pp_q;
  logic [AW-1:0]  pp_word;
  logic [HSW-1:0] pp_half;
  logic [HW-1:0]  half_we;
  logic [CW-1:0]  rd_ch_d, rd_ch_q;
  logic [HSW-1:0] rd_half_d, rd_half_q;

  always_comb begin
    pp_word = AW'(32'(pp_q) / HW);
    pp_half = HSW'(32'(pp_q) % HW);
    pp_d    = pp_q;
    if (pipe_rewind) begin
      pp_d = '0;
    end else if (pipe_in_write || pipe_out_read) begin
      pp_d = (pp_q == PP_LAST) ? '0 : pp_q + PW'(1);
    end
    half_we   = (pipe_in_write && !pipe_rewind) ? (HW'(1) << pp_half) : '0;
    // Readback mux selects are captured alongside the port A read data.
    rd_ch_d   = pipe_ch_sel;
    rd_half_d = pp_half;
  end

  // ---------------- Playback FSM ----------------
  state_e        state_d, state_q;
  logic [AW-1:0] idx_d, idx_q;
  logic [AW:0]   len_d, len_q;
  logic [AW:0]   len_eff;
  logic          at_last;

  always_comb begin
    len_eff = (wave_len == '0 || wave_len > LEN_MAX) ? LEN_MAX : wave_len;
    at_last = (idx_q == AW'(len_q - (AW + 1)'(1)));
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    if (start) begin
      state_d = RUN;
      idx_d   = '0;
      len_d   = len_eff;
    end else if (stop) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (state_q == RUN && pop_en) begin
      if (at_last) begin
        if (one_shot) state_d = HOLD;
        else          idx_d   = '0;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pp_q      <= '0;
      rd_ch_q   <= '0;
      rd_half_q <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= LEN_MAX;
    end else begin
      pp_q      <= pp_d;
      rd_ch_q   <= rd_ch_d;
      rd_half_q <= rd_half_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
    end
  end

  assign sample_idx = idx_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == HOLD);

  // ---------------- Channel RAMs and output mux ----------------
  logic [DATA_W-1:0] a_rdata [NUM_CH];
  logic [DATA_W-1:0] b_rdata [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [HW-1:0] ch_we;
    assign ch_we = (pipe_ch_sel == CW'(c)) ? half_we : '0;

    waveform_ram_ch #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .a_we    (ch_we),
      .a_addr  (pp_word),
      .a_wdata (pipe_in_data),
      .a_rdata (a_rdata[c]),
      .b_addr  (idx_q),
      .b_rdata (b_rdata[c])
    );

    assign wave[c*DATA_W +: DATA_W] = is_from_trigger[c] ? data_from_trig[c*DATA_W +: DATA_W]
                                                         : b_rdata[c];
  end

  always_comb begin
    pipe_out_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch_q == CW'(c)) pipe_out_data = a_rdata[c][rd_half_q*PIPE_W +: PIPE_W];
    end
  end

endmodule

// File: tb/tb_waveform_player_mc.sv
// Directed self-checking bench for waveform_player_mc (4 ch, 2048 x 32).
module tb_waveform_player_mc;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pipe_in_write = 1'b0;
  logic [15:0]  pipe_in_data = '0;
  logic         pipe_out_read = 1'b0;
  logic [15:0]  pipe_out_data;
  logic [1:0]   pipe_ch_sel = '0;
  logic         pipe_rewind = 1'b0;
  logic [11:0]  wave_len = '0;
  logic         one_shot = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pop_en = 1'b0;
  logic [3:0]   is_from_trigger = '0;
  logic [127:0] data_from_trig = '0;
  logic [127:0] wave;
  logic [10:0]  sample_idx;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  waveform_player_mc #(
    .NUM_CH (4),
    .DEPTH  (2048),
    .DATA_W (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pipe_in_write   (pipe_in_write),
    .pipe_in_data    (pipe_in_data),
    .pipe_out_read   (pipe_out_read),
    .pipe_out_data   (pipe_out_data),
    .pipe_ch_sel     (pipe_ch_sel),
    .pipe_rewind     (pipe_rewind),
    .wave_len        (wave_len),
    .one_shot        (one_shot),
    .start           (start),
    .stop            (stop),
    .pop_en          (pop_en),
    .is_from_trigger (is_from_trigger),
    .data_from_trig  (data_from_trig),
    .wave            (wave),
    .sample_idx      (sample_idx),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wch(input int c);
    return wave[c*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rewind();
    pipe_rewind = 1'b1;
    tick();
    pipe_rewind = 1'b0;
  endtask

  task automatic pipe_wr(input logic [1:0] ch, input logic [15:0] d);
    pipe_ch_sel   = ch;
    pipe_in_data  = d;
    pipe_in_write = 1'b1;
    tick();
    pipe_in_write = 1'b0;
  endtask

  // One clk to register the halfword at the pointer, then a read strobe to advance.
  task automatic pipe_rd(input logic [1:0] ch, output logic [15:0] d);
    pipe_ch_sel = ch;
    tick();
    d = pipe_out_data;
    pipe_out_read = 1'b1;
    tick();
    pipe_out_read = 1'b0;
  endtask

  task automatic start_play(input logic [11:0] len, input logic os);
    wave_len = len;
    one_shot = os;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, done);
    end
    vectors++;
    if (sample_idx !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_idx: got %0d expected 0", sample_idx);
    end
    vectors++;
    if (pipe_out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_pipe_out: got %h expected 0000", pipe_out_data);
    end
    vectors++;
    if (wave !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_wave: got %h expected 0", wave);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load_readback();
    logic [15:0] d;
    rewind();
    pipe_wr(2'd1, 16'd5);
    pipe_wr(2'd1, 16'd0);
    pipe_wr(2'd1, 16'd6);
    pipe_wr(2'd1, 16'd0);
    rewind();
    for (int i = 0; i < 4; i++) pipe_wr(2'd2, 16'(i + 1));
    rewind();
    for (int i = 0; i < 4; i++) begin
      pipe_rd(2'd2, d);
      vectors++;
      if (d !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL readback_ch2[%0d]: got %h expected %h", i, d, 16'(i + 1));
      end
    end
    rewind();
    pipe_rd(2'd1, d);
    vectors++;
    if (d !== 16'd5) begin
      miscompares++;
      $display("FAIL readback_ch1_untouched: got %h expected 0005", d);
    end
    pipe_rd(2'd1, d);
    pipe_rd(2'd1, d);
    vectors++;
    if (d !== 16'd6) begin
      miscompares++;
      $display("FAIL readback_ch1_word1: got %h expected 0006", d);
    end
  endtask

  task automatic test_loop();
    logic [31:0] exp_w [6] = '{32'd20, 32'd30, 32'd40, 32'd10, 32'd20, 32'd30};
    logic [10:0] exp_i [6] = '{11'd1, 11'd2, 11'd3, 11'd0, 11'd1, 11'd2};
    logic [31:0] prev;
    rewind();
    for (int w = 0; w < 4; w++) begin
      pipe_wr(2'd0, 16'((w + 1) * 10));
      pipe_wr(2'd0, 16'd0);
    end
    start_play(12'd4, 1'b0);
    vectors++;
    if (wch(0) !== 32'd10 || sample_idx !== 11'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL loop_start: got wave=%0d idx=%0d busy=%b expected 10 0 1",
               wch(0), sample_idx, busy);
    end
    vectors++;
    if (wch(2) !== 32'h0002_0001 || wch(1) !== 32'd5) begin
      miscompares++;
      $display("FAIL loop_other_ch: got ch2=%h ch1=%h expected 00020001 00000005",
               wch(2), wch(1));
    end
    prev = 32'd10;
    for (int i = 0; i < 6; i++) begin
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      vectors++;
      if (sample_idx !== exp_i[i] || wch(0) !== prev) begin
        miscompares++;
        $display("FAIL loop_latency[%0d]: got idx=%0d wave=%0d expected %0d %0d",
                 i, sample_idx, wch(0), exp_i[i], prev);
      end
      tick();
      vectors++;
      if (wch(0) !== exp_w[i] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL loop_wave[%0d]: got wave=%0d busy=%b expected %0d 1",
                 i, wch(0), busy, exp_w[i]);
      end
      if (i == 0) begin
        vectors++;
        if (wch(2) !== 32'h0004_0003) begin
          miscompares++;
          $display("FAIL loop_ch2_word1: got %h expected 00040003", wch(2));
        end
      end
      prev = exp_w[i];
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] exp_w [5] = '{32'd20, 32'd30, 32'd30, 32'd30, 32'd30};
    start_play(12'd3, 1'b1);
    vectors++;
    if (wch(0) !== 32'd10) begin
      miscompares++;
      $display("FAIL oneshot_first: got %0d expected 10", wch(0));
    end
    for (int i = 0; i < 5; i++) begin
      pop_en = 1'b1;
      tick();
      pop_en = 1'b0;
      tick();
      vectors++;
      if (wch(0) !== exp_w[i]) begin
        miscompares++;
        $display("FAIL oneshot_wave[%0d]: got %0d expected %0d", i, wch(0), exp_w[i]);
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || sample_idx !== 11'd2) begin
      miscompares++;
      $display("FAIL oneshot_hold: got done=%b busy=%b idx=%0d expected 1 0 2",
               done, busy, sample_idx);
    end
    start_play(12'd3, 1'b1);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || wch(0) !== 32'd10) begin
      miscompares++;
      $display("FAIL oneshot_restart: got done=%b busy=%b wave=%0d expected 0 1 10",
               done, busy, wch(0));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_idx !== 11'd0) begin
      miscompares++;
      $display("FAIL stop_idle: got busy=%b done=%b idx=%0d expected 0 0 0",
               busy, done, sample_idx);
    end
  endtask

  task automatic test_bypass();
    start_play(12'd4, 1'b0);
    is_from_trigger       = 4'b0010;
    data_from_trig[63:32] = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (wch(1) !== 32'hDEAD_BEEF || wch(0) !== 32'd10) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got ch1=%h ch0=%0d expected deadbeef 10",
               wch(1), wch(0));
    end
    pop_en = 1'b1;
    tick();
    pop_en = 1'b0;
    tick();
    vectors++;
    if (wch(1) !== 32'hDEAD_BEEF || wch(0) !== 32'd20) begin
      miscompares++;
      $display("FAIL bypass_others_play: got ch1=%h ch0=%0d expected deadbeef 20",
               wch(1), wch(0));
    end
    is_from_trigger = 4'b0000;
    #1;
    vectors++;
    if (wch(1) !== 32'd6) begin
      miscompares++;
      $display("FAIL bypass_release: got %h expected 00000006", wch(1));
    end
    data_from_trig = '0;
  endtask

  task automatic test_boundaries();
    logic [15:0] d;
    // start and stop together: start wins, idx back to 0 (was 1).
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (busy !== 1'b1 || sample_idx !== 11'd0) begin
      miscompares++;
      $display("FAIL start_stop_same: got busy=%b idx=%0d expected 1 0", busy, sample_idx);
    end
    // wave_len = 0 means 2048 samples.
    start_play(12'd0, 1'b0);
    pop_en = 1'b1;
    repeat (2047) tick();
    vectors++;
    if (sample_idx !== 11'd2047 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_end: got idx=%0d busy=%b expected 2047 1", sample_idx, busy);
    end
    tick();
    pop_en = 1'b0;
    vectors++;
    if (sample_idx !== 11'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL len0_wrap: got idx=%0d busy=%b expected 0 1", sample_idx, busy);
    end
    // wave_len > DEPTH also means 2048; one-shot holds at 2047.
    start_play(12'd2049, 1'b1);
    pop_en = 1'b1;
    repeat (2048) tick();
    pop_en = 1'b0;
    vectors++;
    if (sample_idx !== 11'd2047 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL len_over_hold: got idx=%0d done=%b expected 2047 1", sample_idx, done);
    end
    // 4096 halfword writes bring the pointer back to 0.
    rewind();
    for (int i = 0; i < 4096; i++) pipe_wr(2'd3, 16'(i));
    pipe_wr(2'd3, 16'hABCD);
    pipe_rd(2'd3, d);
    vectors++;
    if (d !== 16'h0001) begin
      miscompares++;
      $display("FAIL ptr_wrap_next: got %h expected 0001", d);
    end
    rewind();
    pipe_rd(2'd3, d);
    vectors++;
    if (d !== 16'hABCD) begin
      miscompares++;
      $display("FAIL ptr_wrap_overwrite: got %h expected abcd", d);
    end
    // Rewind together with a write: write dropped, pointer 0.
    rewind();
    pipe_ch_sel   = 2'd3;
    pipe_in_data  = 16'h1234;
    pipe_in_write = 1'b1;
    pipe_rewind   = 1'b1;
    tick();
    pipe_in_write = 1'b0;
    pipe_rewind   = 1'b0;
    pipe_rd(2'd3, d);
    vectors++;
    if (d !== 16'hABCD) begin
      miscompares++;
      $display("FAIL rewind_drops_write: got %h expected abcd", d);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    start_play(12'd8, 1'b0);
    pop_en = 1'b1;
    repeat (5) tick();
    pop_en = 1'b0;
    tick();
    vectors++;
    if (sample_idx !== 11'd5 || wch(3) !== 32'h000B_000A) begin
      miscompares++;
      $display("FAIL pre_reset_play: got idx=%0d ch3=%h expected 5 000b000a",
               sample_idx, wch(3));
    end
    pipe_ch_sel = 2'd2;
    rewind();
    tick();
    vectors++;
    if (pipe_out_data !== 16'h0001) begin
      miscompares++;
      $display("FAIL pre_reset_pipe: got %h expected 0001", pipe_out_data);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (wave !== 128'd0 || sample_idx !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset_wave: got wave=%h idx=%0d expected 0 0", wave, sample_idx);
    end
    vectors++;
    if (busy !== 1'b0 || pipe_out_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset_status: got busy=%b pipe=%h expected 0 0000",
               busy, pipe_out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    vectors++;
    if (wch(3) !== 32'h0001_ABCD) begin
      miscompares++;
      $display("FAIL retained_ch3: got %h expected 0001abcd", wch(3));
    end
    pipe_rd(2'd2, d);
    vectors++;
    if (d !== 16'h0001) begin
      miscompares++;
      $display("FAIL retained_ch2_lo: got %h expected 0001", d);
    end
    pipe_rd(2'd2, d);
    vectors++;
    if (d !== 16'h0002) begin
      miscompares++;
      $display("FAIL retained_ch2_hi: got %h expected 0002", d);
    end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_loop();
    test_one_shot();
    test_bypass();
    test_boundaries();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
